// File: rtl/retospect_cfg_sequencer_pkg.sv
// retospect_cfg_pkg: shared state type and scan-chain geometry
// (clockbox followed by the CNB array) for the config sequencer.
package retospect_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ARM,
    DONE
  } state_t;

  localparam int unsigned CLOCKBOX_BITS = 48;
  localparam int unsigned CNB_BITS      = 19;
  localparam int unsigned NUM_CNB       = 25;

  localparam int unsigned CHAIN_LEN_DEF =
    CLOCKBOX_BITS + CNB_BITS * NUM_CNB;

endpackage

// File: rtl/retospect_cfg_sequencer_if.sv
// retospect_cfg_sequencer_if: config byte stream in (in_*) and
// readback byte stream out (out_*). slave = sequencer side.
interface retospect_cfg_sequencer_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/retospect_cfg_sequencer_serdes.sv
// retospect_bit_serdes: byte-to-bit shift-out buffer and bit-to-byte
// readback collector. Ports: clear/load/shift/last controls from the
// sequencer FSM, bs_out sample in; ibuf_bit, ibuf_empty, byte_done and
// byte_data (completed readback byte) out.
module retospect_bit_serdes (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       shift,
  input  logic       last,
  input  logic       bs_out,
  output logic       ibuf_bit,
  output logic       ibuf_empty,
  output logic       byte_done,
  output logic [7:0] byte_data
);

  logic [7:0] ibuf;
  logic [3:0] ibuf_cnt;
  logic [7:0] obuf;
  logic [2:0] obuf_cnt;

  assign ibuf_bit   = ibuf[0];
  assign ibuf_empty = (ibuf_cnt == 4'd0);

  // The final chain bit flushes a partial byte; obuf high bits are
  // already zero because obuf is cleared after every emitted byte.
  assign byte_done = shift && (obuf_cnt == 3'd7 || last);
  assign byte_data = obuf | (8'(bs_out) << obuf_cnt);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      ibuf     <= '0;
      ibuf_cnt <= '0;
      obuf     <= '0;
      obuf_cnt <= '0;
    end else if (load) begin
      ibuf     <= load_data;
      ibuf_cnt <= 4'd8;
    end else if (shift) begin
      ibuf     <= ibuf >> 1;
      // leftover bits past the chain end are dropped
      ibuf_cnt <= last ? 4'd0 : ibuf_cnt - 4'd1;
      if (byte_done) begin
        obuf     <= '0;
        obuf_cnt <= '0;
      end else begin
        obuf     <= byte_data;
        obuf_cnt <= obuf_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/retospect_cfg_sequencer.sv
// retospect_cfg_sequencer: loads the neurochip scan chain LSB-first
// from a byte stream, returns the shifted-out bits as bytes, then
// pulses reset_nn and done.
// Ports: clk, rst_n (sync, active low), start, abort, stream (byte
// in/out handshakes), config_en/bs_in/bs_out (chain), reset_nn, busy,
// done.
module retospect_cfg_sequencer
  import retospect_cfg_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  retospect_cfg_sequencer_if.slave stream,
  output logic config_en,
  output logic bs_in,
  input  logic bs_out,
  output logic reset_nn,
  output logic busy,
  output logic done
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       out_data_q;
  logic             out_valid_q;

  logic       in_ready;
  logic       shift;
  logic       enter_load;
  logic       abort_go;
  logic       full;
  logic       last;
  logic       handshake;
  logic       ibuf_bit;
  logic       ibuf_empty;
  logic       byte_done;
  logic [7:0] byte_data;

  assign full      = (bit_cnt == FULL);
  assign last      = shift && (bit_cnt == LAST);
  assign handshake = in_ready && stream.in_valid;
  assign abort_go  = abort && (state == LOAD || state == ARM);

  assign config_en = shift;
  assign bs_in     = shift && ibuf_bit;
  assign busy      = (state != IDLE);

  assign stream.in_ready  = in_ready;
  assign stream.out_data  = out_data_q;
  assign stream.out_valid = out_valid_q;

  always_comb begin
    state_n    = state;
    in_ready   = 1'b0;
    shift      = 1'b0;
    reset_nn   = 1'b0;
    done       = 1'b0;
    enter_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n    = LOAD;
          enter_load = 1'b1;
        end
      end
      LOAD: begin
        // abort suppresses both the fetch and the shift
        if (abort) begin
          state_n = IDLE;
        end else begin
          in_ready = ibuf_empty && !full;
          shift    = !ibuf_empty && !out_valid_q && !full;
          if (full && !out_valid_q) state_n = ARM;
        end
      end
      ARM: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          reset_nn = 1'b1;
          state_n  = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state <= state_n;
      if (enter_load) begin
        bit_cnt     <= '0;
        out_valid_q <= 1'b0;
      end else if (abort_go) begin
        out_valid_q <= 1'b0;
      end else begin
        if (shift) bit_cnt <= bit_cnt + CNT_W'(1);
        if (byte_done) begin
          out_data_q  <= byte_data;
          out_valid_q <= 1'b1;
        end else if (out_valid_q && stream.out_ready) begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  retospect_bit_serdes u_serdes (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (enter_load),
    .load       (handshake),
    .load_data  (stream.in_data),
    .shift      (shift),
    .last       (last),
    .bs_out     (bs_out),
    .ibuf_bit   (ibuf_bit),
    .ibuf_empty (ibuf_empty),
    .byte_done  (byte_done),
    .byte_data  (byte_data)
  );

endmodule
